umi_sync_fifo: RTL and testbench
================================

// Module: umi_sync_fifo
// PURPOSE
// - Single-clock UMI packet FIFO: buffers full UMI transactions (cmd, dstaddr, srcaddr, data)
//   between a UMI producer and a UMI consumer with valid/ready handshakes on both sides.
// - Decouples stalls downstream from the upstream port.
// - First-word-fall-through: the head entry is always presented on umi_out_*.
// PARAMETERS
// - TARGET  "DEFAULT"  pass-through selector for hard-macro memory; behaviour identical for all values
// - DEPTH   4          number of entries; power of two, >= 2
// - CW      32         UMI command width
// - AW      64         UMI address width
// - DW      512        UMI data width
// PORTS
// - clk             in   1                   single clock for all logic
// - nreset          in   1                   asynchronous active-low reset
// - fifo_full       out  1                   DEPTH entries stored
// - fifo_empty      out  1                   zero entries stored
// - fifo_count      out  $clog2(DEPTH)+1     entries currently stored
// - umi_in_valid    in   1                   producer packet valid
// - umi_in_cmd      in   CW                  producer command
// - umi_in_dstaddr  in   AW                  producer destination address
// - umi_in_srcaddr  in   AW                  producer source address
// - umi_in_data     in   DW                  producer data
// - umi_in_ready    out  1                   FIFO accepts a packet this cycle
// - umi_out_valid   out  1                   head packet valid
// - umi_out_cmd     out  CW                  head command
// - umi_out_dstaddr out  AW                  head destination address
// - umi_out_srcaddr out  AW                  head source address
// - umi_out_data    out  DW                  head data
// - umi_out_ready   in   1                   consumer accepts the head packet
// BEHAVIOUR
// - Storage: DEPTH x (CW+AW+AW+DW) array; {cmd,dstaddr,srcaddr,data} is stored as one word. Memory is not reset.
// - Pointers: wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide and reset to 0.
//   - The MSB is the wrap bit.
//   - empty  = (wr_ptr == rd_ptr).
//   - full   = (MSBs differ) && (lower bits equal).
//   - count  = wr_ptr - rd_ptr, computed modulo 2^($clog2(DEPTH)+1).
// - Ready gating: a flop ready_en resets to 0 and is set to 1 on the first clk edge after nreset deasserts.
//   umi_in_ready = ready_en & ~full. It is combinational from state only and never depends on umi_out_ready.
// - Write: when umi_in_valid & umi_in_ready, store the packet at wr_ptr and increment wr_ptr.
//   The packet is visible on the output on the next cycle (1-cycle latency).
// - Read: umi_out_valid = ~empty, and umi_out_* = mem[rd_ptr].
//   When umi_out_valid & umi_out_ready, increment rd_ptr.
// - Simultaneous read and write while not full: both occur and count is unchanged.
//   When full, no write is accepted even if a read occurs that cycle.
// - Reading while empty or writing while full: no effect; pointers hold.
// - Pointers wrap naturally; ordering is strict FIFO across wrap-around.
// - Reset values:
//   - umi_out_valid=0, umi_in_ready=0, fifo_empty=1, fifo_full=0, fifo_count=0.
//   - umi_out_cmd/dstaddr/srcaddr/data are don't-care while umi_out_valid=0.
// - Reset mid-operation: all stored entries are discarded immediately (asynchronously).
//   After release the FIFO is empty and umi_in_ready rises one cycle later.
// - Once umi_out_valid is high, it and the payload are held stable until the handshake; no packet is dropped or duplicated.
// CONFIGURATION
// - UMI_FIFO_BYPASS_EN defined: when the FIFO is empty and umi_in_valid & umi_out_ready, the input packet passes
//   combinationally to umi_out_* with umi_out_valid=1 (0-cycle latency). It is not stored and pointers are unchanged.
//   umi_out_valid = ~empty | (umi_in_valid & ready_en).
// - UMI_FIFO_BYPASS_EN undefined: no bypass; minimum input-to-output latency is 1 cycle. umi_out_valid = ~empty.
// TESTING
// - Reset release: nreset 0->1 -> in_ready=0 for one cycle, then 1; out_valid=0, count=0, empty=1.
// - Single packet: cmd=0x00000004, dst=0x10, src=0x20, data=0xA5 written with out_ready=1
//   -> same packet appears on umi_out_* one cycle later (0 cycles with bypass), then empty=1.
// - Fill with out_ready=0: write 4 packets (data=1..4) -> full=1, in_ready=0, count=4.
//   A 5th valid is held, not accepted.
// - Drain order: from full, set out_ready=1 -> data 1,2,3,4 delivered on consecutive cycles, then out_valid=0.
// - Throughput and wrap: out_ready toggles every cycle, 20 packets (data=0..19) streamed continuously
//   -> all received in order across pointer wrap, none lost or duplicated, count never exceeds 4.
// - Reset mid-stream: nreset=0 with count=3 -> out_valid=0, count=0 immediately; old data never appears after release.

Source files
------------

// File: rtl/umi_sync_fifo.sv
// umi_sync_fifo: single-clock first-word-fall-through FIFO for full UMI packets.
// Optional feature macro: UMI_FIFO_BYPASS_EN (zero-latency pass-through when empty).
module umi_sync_fifo #(
    parameter        TARGET = "DEFAULT",
    parameter int    DEPTH  = 4,
    parameter int    CW     = 32,
    parameter int    AW     = 64,
    parameter int    DW     = 512
) (
    input  logic                       clk,
    input  logic                       nreset,
    output logic                       fifo_full,
    output logic                       fifo_empty,
    output logic [$clog2(DEPTH):0]     fifo_count,
    input  logic                       umi_in_valid,
    input  logic [CW-1:0]              umi_in_cmd,
    input  logic [AW-1:0]              umi_in_dstaddr,
    input  logic [AW-1:0]              umi_in_srcaddr,
    input  logic [DW-1:0]              umi_in_data,
    output logic                       umi_in_ready,
    output logic                       umi_out_valid,
    output logic [CW-1:0]              umi_out_cmd,
    output logic [AW-1:0]              umi_out_dstaddr,
    output logic [AW-1:0]              umi_out_srcaddr,
    output logic [DW-1:0]              umi_out_data,
    input  logic                       umi_out_ready
);

    localparam int IW = $clog2(DEPTH);   // index bits
    localparam int PW = IW + 1;          // pointer bits, MSB is the wrap bit
    localparam int WW = CW + AW + AW + DW;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ready_en_q, ready_en_d;
    logic [WW-1:0] mem_q [DEPTH];

    logic          empty, full;
    logic          wr_en, rd_en, bypass;
    logic [WW-1:0] in_word, head_word, out_word;

    assign in_word   = {umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data};
    assign head_word = mem_q[rd_ptr_q[IW-1:0]];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[IW] != rd_ptr_q[IW]) && (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);

    assign fifo_empty   = empty;
    assign fifo_full    = full;
    assign fifo_count   = wr_ptr_q - rd_ptr_q;
    // Ready is a function of state only so no combinational path from umi_out_ready.
    assign umi_in_ready = ready_en_q & ~full;

`ifdef UMI_FIFO_BYPASS_EN
    // When empty, the incoming packet is shown directly; if consumed this cycle it is never stored.
    assign bypass        = empty & umi_in_valid & umi_out_ready;
    assign umi_out_valid = ~empty | (umi_in_valid & ready_en_q);
    assign out_word      = empty ? in_word : head_word;
    assign rd_en         = ~empty & umi_out_ready;
`else
    assign bypass        = 1'b0;
    assign umi_out_valid = ~empty;
    assign out_word      = head_word;
    assign rd_en         = umi_out_valid & umi_out_ready;
`endif

    assign wr_en = umi_in_valid & umi_in_ready & ~bypass;

    assign {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data} = out_word;

    // Next-state for pointers and the post-reset ready enable.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ready_en_d = 1'b1;
        if (wr_en) wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        if (rd_en) rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end

    // Control state; async reset discards all entries by collapsing the pointers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ready_en_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ready_en_q <= ready_en_d;
        end
    end

    // Packet storage, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[IW-1:0]] <= in_word;
    end

endmodule

// File: tb/tb_umi_sync_fifo.sv
// Directed self-checking bench for umi_sync_fifo (DEPTH=4).
module tb_umi_sync_fifo;

    localparam int CW = 32, AW = 64, DW = 512;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          fifo_full, fifo_empty;
    logic [2:0]    fifo_count;
    logic          umi_in_valid = 1'b0;
    logic [CW-1:0] umi_in_cmd = '0;
    logic [AW-1:0] umi_in_dstaddr = '0, umi_in_srcaddr = '0;
    logic [DW-1:0] umi_in_data = '0;
    logic          umi_in_ready;
    logic          umi_out_valid;
    logic [CW-1:0] umi_out_cmd;
    logic [AW-1:0] umi_out_dstaddr, umi_out_srcaddr;
    logic [DW-1:0] umi_out_data;
    logic          umi_out_ready = 1'b0;

    int vec = 0;
    int miss = 0;

    always #5 clk = ~clk;

    umi_sync_fifo dut (
        .clk(clk), .nreset(nreset),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
        .umi_in_valid(umi_in_valid), .umi_in_cmd(umi_in_cmd),
        .umi_in_dstaddr(umi_in_dstaddr), .umi_in_srcaddr(umi_in_srcaddr),
        .umi_in_data(umi_in_data), .umi_in_ready(umi_in_ready),
        .umi_out_valid(umi_out_valid), .umi_out_cmd(umi_out_cmd),
        .umi_out_dstaddr(umi_out_dstaddr), .umi_out_srcaddr(umi_out_srcaddr),
        .umi_out_data(umi_out_data), .umi_out_ready(umi_out_ready)
    );

    // advance past the next rising edge; inputs are driven 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // wait to the falling edge to sample settled outputs
    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive(input int d);
        umi_in_cmd     = 32'h4;
        umi_in_dstaddr = 64'h10 + 64'(d);
        umi_in_srcaddr = 64'h20 + 64'(d);
        umi_in_data    = 512'(d);
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        repeat (2) step();
        settle();
        vec++; if (umi_in_ready !== 1'b0) begin miss++; $display("FAIL rst_in_ready got %0b want 0", umi_in_ready); end
        vec++; if (umi_out_valid !== 1'b0) begin miss++; $display("FAIL rst_out_valid got %0b want 0", umi_out_valid); end
        vec++; if (fifo_empty !== 1'b1) begin miss++; $display("FAIL rst_empty got %0b want 1", fifo_empty); end
        vec++; if (fifo_full !== 1'b0) begin miss++; $display("FAIL rst_full got %0b want 0", fifo_full); end
        vec++; if (fifo_count !== 3'd0) begin miss++; $display("FAIL rst_count got %0d want 0", fifo_count); end
        step();
        nreset = 1'b1;
        settle();
        vec++; if (umi_in_ready !== 1'b0) begin miss++; $display("FAIL rel_in_ready_c0 got %0b want 0", umi_in_ready); end
        step();
        settle();
        vec++; if (umi_in_ready !== 1'b1) begin miss++; $display("FAIL rel_in_ready_c1 got %0b want 1", umi_in_ready); end
        vec++; if (umi_out_valid !== 1'b0) begin miss++; $display("FAIL rel_out_valid got %0b want 0", umi_out_valid); end
        step();
    endtask

    task automatic test_single();
        umi_out_ready = 1'b1;
        umi_in_valid  = 1'b1;
        umi_in_cmd = 32'h4; umi_in_dstaddr = 64'h10; umi_in_srcaddr = 64'h20; umi_in_data = 512'hA5;
`ifdef UMI_FIFO_BYPASS_EN
        settle();
        vec++; if (umi_out_valid !== 1'b1 || umi_out_data !== 512'hA5) begin miss++; $display("FAIL single_bypass valid=%0b data=%0h want 1/a5", umi_out_valid, umi_out_data); end
        step();
        umi_in_valid = 1'b0;
        settle();
        vec++; if (fifo_empty !== 1'b1) begin miss++; $display("FAIL single_empty got %0b want 1", fifo_empty); end
`else
        settle();
        vec++; if (umi_out_valid !== 1'b0) begin miss++; $display("FAIL single_lat0 got %0b want 0", umi_out_valid); end
        step();
        umi_in_valid = 1'b0;
        settle();
        vec++; if (umi_out_valid !== 1'b1) begin miss++; $display("FAIL single_valid got %0b want 1", umi_out_valid); end
        vec++; if ({umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr} !== {32'h4, 64'h10, 64'h20})
            begin miss++; $display("FAIL single_hdr got %0h/%0h/%0h want 4/10/20", umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr); end
        vec++; if (umi_out_data !== 512'hA5) begin miss++; $display("FAIL single_data got %0h want a5", umi_out_data); end
        step();
        settle();
        vec++; if (fifo_empty !== 1'b1 || umi_out_valid !== 1'b0) begin miss++; $display("FAIL single_empty empty=%0b valid=%0b want 1/0", fifo_empty, umi_out_valid); end
`endif
        step();
        umi_out_ready = 1'b0;
    endtask

    task automatic test_fill();
        umi_out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(i); umi_in_valid = 1'b1;
            step();
        end
        drive(5);
        settle();
        vec++; if (fifo_full !== 1'b1) begin miss++; $display("FAIL fill_full got %0b want 1", fifo_full); end
        vec++; if (umi_in_ready !== 1'b0) begin miss++; $display("FAIL fill_in_ready got %0b want 0", umi_in_ready); end
        vec++; if (fifo_count !== 3'd4) begin miss++; $display("FAIL fill_count got %0d want 4", fifo_count); end
        step();
        settle();
        vec++; if (fifo_count !== 3'd4 || umi_out_data !== 512'd1) begin miss++; $display("FAIL fill_hold count=%0d head=%0h want 4/1", fifo_count, umi_out_data); end
        step();
        umi_in_valid = 1'b0;
    endtask

    task automatic test_drain();
        umi_out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            settle();
            vec++; if (umi_out_valid !== 1'b1 || umi_out_data !== 512'(i)) begin miss++; $display("FAIL drain_%0d valid=%0b data=%0h want 1/%0h", i, umi_out_valid, umi_out_data, i); end
            step();
        end
        settle();
        vec++; if (umi_out_valid !== 1'b0 || fifo_empty !== 1'b1) begin miss++; $display("FAIL drain_end valid=%0b empty=%0b want 0/1", umi_out_valid, fifo_empty); end
        step();
        umi_out_ready = 1'b0;
    endtask

    // full plus a read in the same cycle: the read happens, the write is refused
    task automatic test_full_rw();
        for (int i = 0; i < 4; i++) begin
            drive(48 + i); umi_in_valid = 1'b1; step();
        end
        drive(52); umi_out_ready = 1'b1;
        step();
        umi_out_ready = 1'b0;
        settle();
        vec++; if (fifo_count !== 3'd3 || umi_out_data !== 512'd49) begin miss++; $display("FAIL fullrw count=%0d head=%0h want 3/31", fifo_count, umi_out_data); end
        step();
        umi_in_valid = 1'b0;
        settle();
        vec++; if (fifo_count !== 3'd4) begin miss++; $display("FAIL fullrw_refill got %0d want 4", fifo_count); end
        umi_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        umi_out_ready = 1'b0;
        settle();
        vec++; if (fifo_empty !== 1'b1) begin miss++; $display("FAIL fullrw_empty got %0b want 1", fifo_empty); end
        step();
    endtask

    task automatic test_back_to_back();
        int tx = 0, rx = 0, m = 0, cyc = 0;
        bit ih, oh;
        umi_out_ready = 1'b1;
        while (rx < 20 && cyc < 200) begin
            umi_in_valid = (tx < 20);
            drive(tx);
            settle();
            vec++; if (fifo_count !== 3'(m)) begin miss++; $display("FAIL stream_count cyc=%0d got %0d want %0d", cyc, fifo_count, m); end
            vec++; if (umi_in_ready !== (m != 4)) begin miss++; $display("FAIL stream_in_ready cyc=%0d got %0b want %0b", cyc, umi_in_ready, m != 4); end
            ih = umi_in_valid & umi_in_ready;
            oh = umi_out_valid & umi_out_ready;
            if (oh) begin
                vec++; if (umi_out_data !== 512'(rx) || umi_out_dstaddr !== 64'h10 + 64'(rx))
                    begin miss++; $display("FAIL stream_data got %0h want %0h", umi_out_data, rx); end
                rx++;
            end
            if (ih) tx++;
`ifdef UMI_FIFO_BYPASS_EN
            if (!(ih && oh && m == 0)) m = m + int'(ih) - int'(oh);
`else
            m = m + int'(ih) - int'(oh);
`endif
            step();
            umi_out_ready = ~umi_out_ready;
            cyc++;
        end
        vec++; if (rx != 20) begin miss++; $display("FAIL stream_total got %0d want 20", rx); end
        umi_in_valid = 1'b0; umi_out_ready = 1'b1;
        repeat (5) step();
        umi_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(256 + i); umi_in_valid = 1'b1; step();
        end
        umi_in_valid = 1'b0;
        settle();
        vec++; if (fifo_count !== 3'd3) begin miss++; $display("FAIL mid_count_pre got %0d want 3", fifo_count); end
        nreset = 1'b0;
        #1;
        vec++; if (umi_out_valid !== 1'b0 || fifo_count !== 3'd0) begin miss++; $display("FAIL mid_async valid=%0b count=%0d want 0/0", umi_out_valid, fifo_count); end
        step();
        nreset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            vec++; if (umi_out_valid !== 1'b0) begin miss++; $display("FAIL mid_stale_%0d got %0b want 0", i, umi_out_valid); end
            step();
        end
        drive(512); umi_in_valid = 1'b1;
        step();
        umi_in_valid = 1'b0;
        settle();
        vec++; if (umi_out_valid !== 1'b1 || umi_out_data !== 512'd512) begin miss++; $display("FAIL mid_new valid=%0b data=%0h want 1/200", umi_out_valid, umi_out_data); end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_drain();
        test_full_rw();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
